// File: rtl/fp_add_scheduler.sv
// Round-robin scheduler that time-shares one external combinational FP32 adder among NUM_REQ requesters.
// Optional macro FP_ADD_SCHED_ZERO_BYPASS_EN returns the non-zero operand when either operand is +/-0.
module fp_add_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*32-1:0]   req_a,
  input  logic [NUM_REQ*32-1:0]   req_b,
  output logic [31:0]             add_a,
  output logic [31:0]             add_b,
  input  logic [31:0]             add_res,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_data,
  output logic                    busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // Requesters hold valid/operands until ready; the response holds until rsp_ready.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   ptr_nxt;
  logic [ID_W-1:0]   tag;
  logic [ID_W-1:0]   grant;
  logic [ID_W:0]     cand;
  logic              found;
  logic              accept_win;
  logic              accept;
  logic [31:0]       sel_a;
  logic [31:0]       sel_b;
  logic [31:0]       capture;

  // Search ptr, ptr+1, ... (mod NUM_REQ) for the first valid requester.
  always_comb begin
    grant = '0;
    found = 1'b0;
    sel_a = '0;
    sel_b = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid[i] && (cand[ID_W-1:0] == ID_W'(i))) begin
          found = 1'b1;
          grant = ID_W'(i);
          sel_a = req_a[32*i +: 32];
          sel_b = req_b[32*i +: 32];
        end
      end
    end
  end

  always_comb begin
    accept_win = (state == IDLE) || ((state == RESP) && rsp_ready);
    accept     = rst_n && accept_win && found;
    req_ready  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept && (grant == ID_W'(i))) begin
        req_ready[i] = 1'b1;
      end
    end
    if (grant == ID_W'(NUM_REQ - 1)) begin
      ptr_nxt = '0;
    end else begin
      ptr_nxt = grant + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = accept ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef FP_ADD_SCHED_ZERO_BYPASS_EN
  // The shared adder assumes an implicit leading 1 even for exponent 0, so zeros are handled here.
  always_comb begin
    capture = add_res;
    if ((add_a[30:0] == 31'd0) && (add_b[30:0] == 31'd0)) begin
      capture = {add_a[31] & add_b[31], 31'd0};
    end else if (add_a[30:0] == 31'd0) begin
      capture = add_b;
    end else if (add_b[30:0] == 31'd0) begin
      capture = add_a;
    end
  end
`else
  assign capture = add_res;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      tag       <= '0;
      add_a     <= '0;
      add_b     <= '0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_valid <= 1'b0;
    end else begin
      if (accept) begin
        add_a <= sel_a;
        add_b <= sel_b;
        tag   <= grant;
        ptr   <= ptr_nxt;
      end
      if (state == ISSUE) begin
        rsp_data  <= capture;
        rsp_id    <= tag;
        rsp_valid <= 1'b1;
      end else if ((state == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Self-checking bench for fp_add_scheduler: table of single operations plus fairness, wrap,
// backpressure, reset and zero-operand sequences, with an external FP adder model on add_res.
module tb_fp_add_scheduler;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [31:0]           add_a;
  logic [31:0]           add_b;
  logic [31:0]           add_res;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_data;
  logic                  busy;

  fp_add_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .add_a(add_a), .add_b(add_b), .add_res(add_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- adder model ----------------
  // Exact for normal operands; an exponent-0 operand yields a poison NaN, standing in for the
  // shared adder mishandling zeros.
  function automatic real f2r(input logic [31:0] a);
    logic [63:0] db;
    db = {a[31], {3'b000, a[30:23]} + 11'd896, a[22:0], 29'd0};
    return $bitstoreal(db);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] db;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    db = $realtobits(r);
    e  = db[62:52] - 11'd896;
    return {db[63], e[7:0], db[51:29]};
  endfunction

  function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b);
    if ((a[30:23] == 8'd0) || (b[30:23] == 8'd0)) return 32'h7FC0_0000;
    return r2f(f2r(a) + f2r(b));
  endfunction

  assign add_res = fp_model(add_a, add_b);

  // ---------------- scoreboard ----------------
  logic [ID_W+31:0] exp_q[$];
  int               grant_q[$];
  int               grant_cyc_q[$];
  logic [ID_W+31:0] mon_item;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_rsp: got id %0d data %h, expected no response", rsp_id, rsp_data);
        end else begin
          mon_item = exp_q.pop_front();
          check("rsp_id", 64'(rsp_id), 64'(mon_item[ID_W+31:32]));
          check("rsp_data", 64'(rsp_data), 64'(mon_item[31:0]));
        end
      end
      if ((req_valid & req_ready) != '0) begin
        check("ready_only_valid", 64'(req_ready & ~req_valid), 64'd0);
        for (int i = 0; i < NUM_REQ; i++) begin
          if (req_ready[i]) begin
            grant_q.push_back(i);
            grant_cyc_q.push_back(cyc);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_ops(input int id, input logic [31:0] a, input logic [31:0] b);
    req_a[id*32 +: 32] = a;
    req_b[id*32 +: 32] = b;
  endtask

  task automatic push_exp(input int id, input logic [31:0] d);
    exp_q.push_back({ID_W'(id), d});
  endtask

  // Returns at posedge+1 of the acceptance edge, with that requester's valid dropped.
  task automatic wait_accept(input int id);
    logic [NUM_REQ-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        check("req_ready_onehot", 64'(req_ready), 64'(oh));
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
        return;
      end
    end
    chk_cnt++;
    $display("FAIL accept_timeout: requester %0d not granted, expected grant within 30 cycles", id);
  endtask

  task automatic drain();
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if ((exp_q.size() == 0) && !rsp_valid) break;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_grants(input string name, input int g0, input int g1);
    check({name, "_count"}, 64'(grant_q.size()), 64'd2);
    if (grant_q.size() >= 2) begin
      check({name, "_first"}, 64'(grant_q[0]), 64'(g0));
      check({name, "_second"}, 64'(grant_q[1]), 64'(g1));
    end
  endtask

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[7];
  logic [31:0] fair_a[4];
  logic [31:0] fair_exp[4];
  int          fair_seq[6];
  int          ngr;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion well before 100000");
    $fatal(1);
  end

  initial begin
`ifdef FP_ADD_SCHED_ZERO_BYPASS_EN
    vecs[4] = '{2, 32'h0000_0000, 32'hC0A0_0000, 32'hC0A0_0000};
    vecs[5] = '{1, 32'h4000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[6] = '{0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
`else
    vecs[4] = '{2, 32'h0000_0000, 32'hC0A0_0000, 32'h7FC0_0000};
    vecs[5] = '{1, 32'h4000_0000, 32'h8000_0000, 32'h7FC0_0000};
    vecs[6] = '{0, 32'h8000_0000, 32'h8000_0000, 32'h7FC0_0000};
`endif
    vecs[0] = '{0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
    vecs[1] = '{1, 32'h3FC0_0000, 32'h4020_0000, 32'h4080_0000};
    vecs[2] = '{3, 32'hC0A0_0000, 32'h3F80_0000, 32'hC080_0000};
    vecs[3] = '{2, 32'h4120_0000, 32'hC000_0000, 32'h4100_0000};
    fair_a   = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
    fair_exp = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000};
    fair_seq = '{0, 1, 2, 3, 0, 1};

    // Reset values, with requests present to show req_ready is forced low.
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    #2 req_valid = '1;
    #1;
    check("rst_add_a", 64'(add_a), 64'd0);
    check("rst_add_b", 64'(add_b), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fairness: all requesters held valid from ptr=0.
    for (int i = 0; i < NUM_REQ; i++) set_ops(i, fair_a[i], 32'h3F80_0000);
    for (int k = 0; k < 6; k++) push_exp(fair_seq[k], fair_exp[fair_seq[k]]);
    grant_q.delete();
    grant_cyc_q.delete();
    req_valid = '1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      #1;
      if (grant_q.size() > 1) check("fair_busy", 64'(busy), 64'd1);
      if (grant_q.size() >= 6) begin
        @(posedge clk);
        #1;
        req_valid = '0;
        break;
      end
    end
    check("fair_grant_count", 64'(grant_q.size()), 64'd6);
    ngr = (grant_q.size() < 6) ? grant_q.size() : 6;
    for (int k = 0; k < ngr; k++) begin
      check("fair_grant", 64'(grant_q[k]), 64'(fair_seq[k]));
      if (k > 0) check("fair_spacing", 64'(grant_cyc_q[k] - grant_cyc_q[k-1]), 64'd2);
    end
    drain();

    // Table of single operations, including zero operands.
    for (int v = 0; v < 7; v++) begin
      set_ops(vecs[v].id, vecs[v].a, vecs[v].b);
      push_exp(vecs[v].id, vecs[v].exp);
      req_valid[vecs[v].id] = 1'b1;
      wait_accept(vecs[v].id);
      @(negedge clk);
      check("vec_issue_rsp_valid", 64'(rsp_valid), 64'd0);
      check("vec_add_a", 64'(add_a), 64'(vecs[v].a));
      check("vec_add_b", 64'(add_b), 64'(vecs[v].b));
      @(negedge clk);
      check("vec_rsp_valid", 64'(rsp_valid), 64'd1);
      check("vec_rsp_id", 64'(rsp_id), 64'(vecs[v].id));
      check("vec_rsp_data", 64'(rsp_data), 64'(vecs[v].exp));
      @(posedge clk);
      #1;
    end
    drain();

    // Wrap priority: grant 2 leaves ptr=3, then 0 and 1 compete.
    set_ops(2, 32'h4040_0000, 32'h3F80_0000);
    push_exp(2, 32'h4080_0000);
    req_valid[2] = 1'b1;
    wait_accept(2);
    grant_q.delete();
    set_ops(0, 32'h3F80_0000, 32'h3F80_0000);
    set_ops(1, 32'h4000_0000, 32'h3F80_0000);
    push_exp(0, 32'h4000_0000);
    push_exp(1, 32'h4040_0000);
    req_valid[1:0] = 2'b11;
    wait_accept(0);
    wait_accept(1);
    drain();
    check_grants("wrap", 0, 1);

    // Backpressure: response held for 5 cycles while requester 3 waits.
    rsp_ready = 1'b0;
    set_ops(2, 32'h4120_0000, 32'hC000_0000);
    push_exp(2, 32'h4100_0000);
    req_valid[2] = 1'b1;
    wait_accept(2);
    set_ops(3, 32'h3F80_0000, 32'h3F80_0000);
    push_exp(3, 32'h4000_0000);
    req_valid[3] = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      check("bp_rsp_id", 64'(rsp_id), 64'd2);
      check("bp_rsp_data", 64'(rsp_data), 64'h4100_0000);
      check("bp_req_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_accept_same_cycle", 64'(req_ready), 64'b1000);
    @(posedge clk);
    #1 req_valid[3] = 1'b0;
    drain();

    // Reset during ISSUE: operation discarded, then ptr restarts at 0.
    set_ops(0, 32'h3F80_0000, 32'h4000_0000);
    req_valid[0] = 1'b1;
    wait_accept(0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_add_a", 64'(add_a), 64'd0);
    check("mid_rst_add_b", 64'(add_b), 64'd0);
    check("mid_rst_rsp_data", 64'(rsp_data), 64'd0);
    check("mid_rst_rsp_id", 64'(rsp_id), 64'd0);
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    set_ops(1, 32'h4080_0000, 32'h3F80_0000);
    set_ops(3, 32'h4000_0000, 32'h4000_0000);
    req_valid = 4'b1010;
    #1;
    check("mid_rst_req_ready", 64'(req_ready), 64'd0);
    exp_q.delete();
    grant_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_exp(1, 32'h40A0_0000);
    push_exp(3, 32'h4080_0000);
    wait_accept(1);
    wait_accept(3);
    drain();
    check_grants("post_rst", 1, 3);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
